// File: rtl/param_load_counter_pkg.sv
// Shared types for the parametrised load counter: FSM state encoding and mode constants.
package param_load_counter_pkg;

    typedef enum logic [1:0] {
        PLC_IDLE = 2'd0,
        PLC_RUN  = 2'd1,
        PLC_DONE = 2'd2
    } plc_state_t;

    localparam logic PLC_MODE_CONT    = 1'b0;
    localparam logic PLC_MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/plc_snapshot.sv
// WIDTH-bit capture register: holds the count seen on the last edge where snap was high.
module plc_snapshot #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             snap,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            value <= RST_VAL;
        end else if (snap) begin
            value <= count;
        end
    end

endmodule

// File: rtl/param_load_counter.sv
// Loadable up/down counter with programmable terminal value, continuous or one-shot.
// Optional count snapshot port enabled by PARAM_LOAD_COUNTER_SNAPSHOT_EN.
module param_load_counter
    import param_load_counter_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             restart_i,
    input  logic             up_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             busy_o,
    output logic             done_o
`ifdef PARAM_LOAD_COUNTER_SNAPSHOT_EN
    ,
    input  logic             snap_i,
    output logic [WIDTH-1:0] snap_o
`endif
);

    plc_state_t       state_q;
    plc_state_t       state_next;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_next;
    logic             tc_q;
    logic             tc_next;

    logic [WIDTH-1:0] term;
    logic             active;
    logic             terminal;
    logic             oneshot;

    assign term     = up_i ? limit_i : '0;
    assign active   = en_i && (state_q != PLC_DONE);
    assign terminal = active && (count_q == term);
    assign oneshot  = (mode_i == PLC_MODE_ONESHOT);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= PLC_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // FSM: next-state logic; load/restart always pull the counter back to IDLE
    always_comb begin
        state_next = state_q;
        if (load_i || restart_i) begin
            state_next = PLC_IDLE;
        end else begin
            case (state_q)
                PLC_IDLE: begin
                    if (en_i) begin
                        state_next = (terminal && oneshot) ? PLC_DONE : PLC_RUN;
                    end
                end
                PLC_RUN: begin
                    if (!en_i) begin
                        state_next = PLC_IDLE;
                    end else if (terminal && oneshot) begin
                        state_next = PLC_DONE;
                    end
                end
                PLC_DONE: state_next = PLC_DONE;
                default:  state_next = PLC_IDLE;
            endcase
        end
    end

    // FSM: outputs decoded from the state register only
    always_comb begin
        busy_o = (state_q == PLC_RUN);
        done_o = (state_q == PLC_DONE);
    end

    // Datapath priority: load > restart > terminal event > step > hold
    always_comb begin
        count_next  = count_q;
        reload_next = reload_q;
        tc_next     = 1'b0;
        if (load_i) begin
            count_next  = load_val_i;
            reload_next = load_val_i;
        end else if (restart_i) begin
            count_next = reload_q;
        end else if (terminal) begin
            tc_next = 1'b1;
            if (mode_i == PLC_MODE_CONT) begin
                count_next = reload_q;
            end
        end else if (active) begin
            count_next = up_i ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= RST_VAL;
            reload_q <= RST_VAL;
            tc_q     <= 1'b0;
        end else begin
            count_q  <= count_next;
            reload_q <= reload_next;
            tc_q     <= tc_next;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;

`ifdef PARAM_LOAD_COUNTER_SNAPSHOT_EN
    plc_snapshot #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_snapshot (
        .clk   (clk),
        .reset (reset),
        .snap  (snap_i),
        .count (count_q),
        .value (snap_o)
    );
`endif

endmodule

// File: tb/tb_param_load_counter.sv
// Self-checking bench for param_load_counter (WIDTH=4, RST_VAL=0): vector table plus
// hand-written multi-cycle sequences, checked through an expected-value queue.
module tb_param_load_counter;

    localparam int W  = 4;
    localparam int EW = W + 3;

    typedef struct {
        logic         rst;
        logic         en;
        logic         load;
        logic [W-1:0] load_val;
        logic         restart;
        logic         up;
        logic         mode;
        logic [W-1:0] limit;
        logic [W-1:0] cnt;
        logic         tc;
        logic         busy;
        logic         done;
    } vec_t;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         en_i;
    logic         load_i;
    logic [W-1:0] load_val_i;
    logic         restart_i;
    logic         up_i;
    logic         mode_i;
    logic [W-1:0] limit_i;
    logic [W-1:0] count_o;
    logic         tc_o;
    logic         busy_o;
    logic         done_o;
`ifdef PARAM_LOAD_COUNTER_SNAPSHOT_EN
    logic         snap_i;
    logic [W-1:0] snap_o;
`endif

    param_load_counter #(
        .WIDTH   (W),
        .RST_VAL (4'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .restart_i  (restart_i),
        .up_i       (up_i),
        .mode_i     (mode_i),
        .limit_i    (limit_i),
        .count_o    (count_o),
        .tc_o       (tc_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
`ifdef PARAM_LOAD_COUNTER_SNAPSHOT_EN
        ,
        .snap_i     (snap_i),
        .snap_o     (snap_o)
`endif
    );

    // Scoreboard
    logic [EW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    function automatic vec_t mk(input int rst, input int en, input int load, input int lv,
                                input int restart, input int up, input int mode, input int lim,
                                input int cnt, input int tc, input int busy, input int done);
        vec_t v;
        v.rst      = (rst != 0);
        v.en       = (en != 0);
        v.load     = (load != 0);
        v.load_val = W'(lv);
        v.restart  = (restart != 0);
        v.up       = (up != 0);
        v.mode     = (mode != 0);
        v.limit    = W'(lim);
        v.cnt      = W'(cnt);
        v.tc       = (tc != 0);
        v.busy     = (busy != 0);
        v.done     = (done != 0);
        return v;
    endfunction

    task automatic check_outputs(input string tag, input int idx);
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        got = {count_o, tc_o, busy_o, done_o};
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s[%0d] scoreboard empty", tag, idx);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s[%0d] got count=%0d tc=%b busy=%b done=%b, expected count=%0d tc=%b busy=%b done=%b",
                         tag, idx, got[EW-1:3], got[2], got[1], got[0],
                         exp[EW-1:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    // Driver: apply one vector's inputs, push expectation, sample #1 after the edge
    task automatic apply(input vec_t v, input string tag, input int idx);
        reset      = v.rst;
        en_i       = v.en;
        load_i     = v.load;
        load_val_i = v.load_val;
        restart_i  = v.restart;
        up_i       = v.up;
        mode_i     = v.mode;
        limit_i    = v.limit;
        exp_q.push_back({v.cnt, v.tc, v.busy, v.done});
        @(posedge clk);
        #1;
        check_outputs(tag, idx);
    endtask

`ifdef PARAM_LOAD_COUNTER_SNAPSHOT_EN
    task automatic check_snap(input string tag, input logic [W-1:0] exp);
        checks++;
        if (snap_o !== exp) begin
            failures++;
            $display("FAIL %s got snap=%0d expected snap=%0d", tag, snap_o, exp);
        end
    endtask
`endif

    initial begin
        reset = 1'b0; en_i = 1'b0; load_i = 1'b0; load_val_i = '0;
        restart_i = 1'b0; up_i = 1'b0; mode_i = 1'b0; limit_i = '0;
`ifdef PARAM_LOAD_COUNTER_SNAPSHOT_EN
        snap_i = 1'b0;
`endif

        //          rst en ld lv rs up md lim   cnt tc by dn
        // reset, then restart shows reload register is 0
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0,  0,   0, 0, 0, 0));
        // continuous up: load 9, limit 12
        vecs.push_back(mk(1, 0, 1, 9, 0, 1, 0, 12,   9, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 12,  10, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 12,  11, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 12,  12, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 12,   9, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 12,  10, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 12,  11, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 12,  12, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 12,   9, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 12,   9, 0, 0, 0));
        // one-shot down from 3
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 1, 12,   3, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 12,   2, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 12,   1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 12,   0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 12,   0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 12,   0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 12,   0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 12,   3, 0, 0, 0));
        // priority: load beats restart and enable
        vecs.push_back(mk(1, 1, 1, 5, 1, 1, 0, 12,   5, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 12,   6, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 12,   5, 0, 0, 0));
        // restart on a terminal edge suppresses the pulse
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0,  6,   6, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 0,  6,   5, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  6,   5, 0, 0, 0));
        // limit equal to reload: back-to-back pulses
        vecs.push_back(mk(1, 0, 1, 5, 0, 1, 0,  5,   5, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0,  5,   5, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0,  5,   5, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  5,   5, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], "vec", i);
        end

        // past-limit wrap: 14,15,0,...,12 then back to 14
        apply(mk(1, 0, 1, 14, 0, 1, 0, 12, 14, 0, 0, 0), "wrap_load", 0);
        for (int i = 0; i < 14; i++) begin
            apply(mk(1, 1, 0, 0, 0, 1, 0, 12, (15 + i) % 16, 0, 1, 0), "wrap_step", i);
        end
        apply(mk(1, 1, 0, 0, 0, 1, 0, 12, 14, 1, 1, 0), "wrap_term", 0);
        apply(mk(1, 1, 0, 0, 0, 1, 0, 12, 15, 0, 1, 0), "wrap_step", 14);

        // mid-run reset clears count and the reload register
        apply(mk(0, 1, 0, 0, 0, 1, 0, 12, 0, 0, 0, 0), "midrun_reset", 0);
        apply(mk(1, 0, 0, 0, 1, 1, 0, 12, 0, 0, 0, 0), "reset_reload", 0);

        // one-shot up with random limit reaches DONE exactly at limit
        begin
            int lim;
            lim = $urandom_range(3, 10);
            apply(mk(1, 0, 1, 1, 0, 1, 1, lim, 1, 0, 0, 0), "rand_load", lim);
            for (int c = 2; c <= lim; c++) begin
                apply(mk(1, 1, 0, 0, 0, 1, 1, lim, c, 0, 1, 0), "rand_step", c);
            end
            apply(mk(1, 1, 0, 0, 0, 1, 1, lim, lim, 1, 0, 1), "rand_term", lim);
            apply(mk(1, 1, 0, 0, 0, 1, 1, lim, lim, 0, 0, 1), "rand_hold", lim);
            apply(mk(1, 0, 1, 2, 0, 1, 1, lim, 2, 0, 0, 0), "rand_reload", lim);
        end

`ifdef PARAM_LOAD_COUNTER_SNAPSHOT_EN
        apply(mk(1, 0, 1, 6, 0, 1, 0, 15, 6, 0, 0, 0), "snap_load", 0);
        apply(mk(1, 1, 0, 0, 0, 1, 0, 15, 7, 0, 1, 0), "snap_step", 0);
        snap_i = 1'b1;
        apply(mk(1, 1, 0, 0, 0, 1, 0, 15, 8, 0, 1, 0), "snap_step", 1);
        snap_i = 1'b0;
        check_snap("snap_capture", 4'd7);
        apply(mk(1, 1, 0, 0, 0, 1, 0, 15, 9, 0, 1, 0), "snap_step", 2);
        check_snap("snap_hold", 4'd7);
        apply(mk(0, 1, 0, 0, 0, 1, 0, 15, 0, 0, 0, 0), "snap_reset", 0);
        check_snap("snap_reset", 4'd0);
`endif

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
